// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic definitions: divider states and default operand width
package arith_pkg;

   localparam int DEFAULT_SIZE = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/parametric_RCA.sv
// rtl/parametric_RCA.sv - parametric ripple-carry adder
module parametric_RCA #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
   import arith_pkg::*;
#(
   parameter int SIZE = DEFAULT_SIZE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] dividend,
   input  logic [SIZE-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] quotient,
   output logic [SIZE-1:0] remainder,
   output logic            div_by_zero
);

   localparam int CW = $clog2(SIZE + 1);

   div_state_t      state;
   logic [CW-1:0]   count;
   logic [SIZE:0]   pr;
   logic [SIZE-1:0] q_reg;
   logic [SIZE-1:0] dvs;

   logic [SIZE:0]   shifted;
   logic [SIZE:0]   trial;
   logic [SIZE:0]   pr_next;
   logic [SIZE-1:0] q_next;
   logic            cout;
   logic            no_borrow;

   assign shifted = {pr[SIZE-1:0], q_reg[SIZE-1]};

   parametric_RCA #(.WIDTH(SIZE + 1)) u_sub (
      .x   (shifted),
      .y   (~{1'b0, dvs}),
      .ci  (1'b1),
      .sum (trial),
      .cout(cout)
   );

   // A set top bit would mean the true shifted value exceeds any divisor, so it can never borrow.
   assign no_borrow = cout | pr[SIZE];
   assign pr_next   = no_borrow ? trial : shifted;
   assign q_next    = {q_reg[SIZE-2:0], no_borrow};

   // busy/done are registered views of the state, so both lag it by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         pr          <= '0;
         q_reg       <= '0;
         dvs         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (state == CALC);
         done <= (state == DONE);
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dvs   <= divisor;
                  q_reg <= dividend;
                  pr    <= '0;
                  count <= CW'(SIZE);
                  if (divisor == '0) begin
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               pr    <= pr_next;
               q_reg <= q_next;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state       <= DONE;
                  quotient    <= q_next;
                  remainder   <= pr_next[SIZE-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
